// File: rtl/sin_cos_cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sin_cos_cordic_pkg
//  Brief    : Shared constants and types for the sine/cosine CORDIC engine.
//  Revision : 1.0 - initial release
// ============================================================================
package sin_cos_cordic_pkg;

    localparam int ATAN_LEN = 30;

    // atan(2^-i) in turns, scaled by 2^32
    localparam logic [31:0] ATAN_TURNS [0:ATAN_LEN-1] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001
    };

    // 1/K of the converged CORDIC gain, Q2.30
    localparam logic [31:0] CORDIC_GAIN_INV = 32'h26DD3B6A;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ROTATE = 2'd1;
    localparam state_t ST_FIXUP  = 2'd2;

    typedef logic [1:0] quad_t;

    function automatic logic [31:0] atan_lookup(input int unsigned idx);
        logic [31:0] r_val;
        r_val = '0;
        if (idx < ATAN_LEN) r_val = ATAN_TURNS[idx[4:0]];
        return r_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sin_cos_cordic_micro_rotation.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_micro_rotation
//  Brief    : Combinational single CORDIC rotation-mode iteration.
//  Revision : 1.0 - initial release
// ============================================================================
module cordic_micro_rotation
    import sin_cos_cordic_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ITER_CNT_WIDTH = 5
) (
    input  logic signed [DATA_WIDTH+1:0] i_x,
    input  logic signed [DATA_WIDTH+1:0] i_y,
    input  logic signed [DATA_WIDTH:0]   i_z,
    input  logic [ITER_CNT_WIDTH-1:0]    i_iter,
    output logic signed [DATA_WIDTH+1:0] o_x,
    output logic signed [DATA_WIDTH+1:0] o_y,
    output logic signed [DATA_WIDTH:0]   o_z
);

    logic [63:0]                  w_atan_wide;
    logic signed [DATA_WIDTH:0]   w_atan;
    logic signed [DATA_WIDTH+1:0] w_x_sh;
    logic signed [DATA_WIDTH+1:0] w_y_sh;
    logic                         w_pos;

    // Table is in 2^-32 turns; rescale to the angle width in use
    assign w_atan_wide = {atan_lookup(32'(i_iter)), 32'd0} >> (64 - DATA_WIDTH);
    assign w_atan      = signed'(w_atan_wide[DATA_WIDTH:0]);

    assign w_x_sh = i_x >>> i_iter;
    assign w_y_sh = i_y >>> i_iter;
    assign w_pos  = ~i_z[DATA_WIDTH];

    assign o_x = w_pos ? (i_x - w_y_sh) : (i_x + w_y_sh);
    assign o_y = w_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);
    assign o_z = w_pos ? (i_z - w_atan) : (i_z + w_atan);

endmodule
`default_nettype wire

// File: rtl/sin_cos_cordic.sv
`default_nettype none
// ============================================================================
//  Module   : sin_cos_cordic
//  Brief    : Iterative CORDIC sine/cosine with quadrant folding.
//             SIN_COS_CORDIC_ROUND_EN: round-to-nearest and clamp to +/-1.0.
//  Revision : 1.0 - initial release
// ============================================================================
module sin_cos_cordic
    import sin_cos_cordic_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ITERATIONS     = 30,
    parameter int ITER_CNT_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sin_calc_start,
    input  logic [DATA_WIDTH-1:0] in_angle,
    input  logic                  in_sine_cosine,
    output logic                  busy,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_value
);

    localparam int XW = DATA_WIDTH + 2;
    localparam int ZW = DATA_WIDTH + 1;
`ifdef SIN_COS_CORDIC_ROUND_EN
    localparam int C_GUARD = 2;
`else
    localparam int C_GUARD = 0;
`endif
    localparam logic [63:0] C_GAIN_WIDE = {CORDIC_GAIN_INV, 32'd0} >> (64 - DATA_WIDTH - C_GUARD);
    localparam logic signed [XW-1:0] C_X_INIT = signed'(C_GAIN_WIDE[XW-1:0]);
    localparam logic [ITER_CNT_WIDTH-1:0] C_LAST    = ITER_CNT_WIDTH'(ITERATIONS - 1);
    localparam logic [ITER_CNT_WIDTH-1:0] C_CNT_ONE = ITER_CNT_WIDTH'(1);

    state_t                    r_state;
    logic signed [XW-1:0]      r_x;
    logic signed [XW-1:0]      r_y;
    logic signed [ZW-1:0]      r_z;
    logic [ITER_CNT_WIDTH-1:0] r_cnt;
    quad_t                     r_quad;
    logic                      r_sel;
    logic                      r_valid;
    logic [DATA_WIDTH-1:0]     r_value;

    logic signed [XW-1:0]      w_x_next;
    logic signed [XW-1:0]      w_y_next;
    logic signed [ZW-1:0]      w_z_next;
    logic signed [XW-1:0]      w_pick;
    logic [DATA_WIDTH-1:0]     w_result;

    cordic_micro_rotation #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ITER_CNT_WIDTH (ITER_CNT_WIDTH)
    ) u_rot (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_z    (r_z),
        .i_iter (r_cnt),
        .o_x    (w_x_next),
        .o_y    (w_y_next),
        .o_z    (w_z_next)
    );

    // Unfold the first-quadrant result back to the requested quadrant
    always_comb begin
        w_pick = r_y;
        case (r_quad)
            2'd0:    w_pick = r_sel ?  r_y :  r_x;
            2'd1:    w_pick = r_sel ?  r_x : -r_y;
            2'd2:    w_pick = r_sel ? -r_y : -r_x;
            default: w_pick = r_sel ? -r_x :  r_y;
        endcase
    end

`ifdef SIN_COS_CORDIC_ROUND_EN
    localparam logic signed [XW-1:0] C_HALF = XW'(1) <<< (C_GUARD - 1);
    localparam logic signed [XW-1:0] C_ONE  = XW'(1) <<< (DATA_WIDTH - 2);
    logic signed [XW-1:0] w_rnd;

    always_comb begin
        w_rnd = (w_pick + C_HALF) >>> C_GUARD;
        if (w_rnd > C_ONE)
            w_rnd = C_ONE;
        else if (w_rnd < -C_ONE)
            w_rnd = -C_ONE;
        w_result = w_rnd[DATA_WIDTH-1:0];
    end
`else
    assign w_result = w_pick[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cnt   <= '0;
            r_quad  <= '0;
            r_sel   <= 1'b0;
            r_valid <= 1'b0;
            r_value <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sin_calc_start) begin
                        r_quad  <= in_angle[DATA_WIDTH-1:DATA_WIDTH-2];
                        r_sel   <= in_sine_cosine;
                        r_x     <= C_X_INIT;
                        r_y     <= '0;
                        r_z     <= {3'b000, in_angle[DATA_WIDTH-3:0]};
                        r_cnt   <= '0;
                        r_state <= ST_ROTATE;
                    end
                end
                ST_ROTATE: begin
                    r_x   <= w_x_next;
                    r_y   <= w_y_next;
                    r_z   <= w_z_next;
                    r_cnt <= r_cnt + C_CNT_ONE;
                    if (r_cnt == C_LAST) r_state <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    r_value <= w_result;
                    r_valid <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_valid;
    assign out_value = r_value;

endmodule
`default_nettype wire

// File: tb/tb_sin_cos_cordic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sin_cos_cordic
//  Brief    : Self-checking bench for sin_cos_cordic against a real-math model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sin_cos_cordic;

    localparam int  IT  = 30;
    localparam int  LAT = IT + 1;
    localparam longint TOL = 32;
    localparam longint ONE = 64'sd1073741824;

    logic        clock = 1'b0;
    logic        reset;
    logic        sin_calc_start;
    logic [31:0] in_angle;
    logic        in_sine_cosine;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_value;

    int n_checks = 0;
    int n_fail   = 0;

    sin_cos_cordic #(
        .DATA_WIDTH     (32),
        .ITERATIONS     (IT),
        .ITER_CNT_WIDTH (5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sin_calc_start (sin_calc_start),
        .in_angle       (in_angle),
        .in_sine_cosine (in_sine_cosine),
        .busy           (busy),
        .out_valid      (out_valid),
        .out_value      (out_value)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // sin/cos of the angle in turns, as a Q2.30 integer
    function automatic longint model(input logic [31:0] a, input logic s);
        real th, r;
        th = 6.283185307179586 * real'(longint'({32'd0, a})) / 4294967296.0;
        r  = s ? $sin(th) : $cos(th);
        return longint'(r * 1073741824.0);
    endfunction

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint got, input longint exp);
        n_checks++;
        assert ((got - exp) <= TOL && (exp - got) <= TOL) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, got, exp, TOL);
        end
    endtask

    // Pulse start now; return the captured result and edges to out_valid
    task automatic run_op(input logic [31:0] a, input logic s,
                          output longint v, output int lat);
        in_angle       = a;
        in_sine_cosine = s;
        sin_calc_start = 1'b1;
        @(posedge clock);
        #1 sin_calc_start = 1'b0;
        lat = 0;
        v   = 0;
        while (lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            if (out_valid) begin
                v = longint'($signed(out_value));
                break;
            end
        end
    endtask

    logic [31:0] d_ang [7];
    logic        d_sel [7];
    longint      d_exp [7];

    initial begin
        longint v;
        int     lat;
        int     pulses;
        int     e;
        logic [31:0] ra;
        logic        rs;

        d_ang[0] = 32'h0000_0000; d_sel[0] = 1'b1; d_exp[0] = 0;
        d_ang[1] = 32'h4000_0000; d_sel[1] = 1'b1; d_exp[1] = ONE;
        d_ang[2] = 32'h8000_0000; d_sel[2] = 1'b0; d_exp[2] = -ONE;
        d_ang[3] = 32'hC000_0000; d_sel[3] = 1'b1; d_exp[3] = -ONE;
        d_ang[4] = 32'hC000_0000; d_sel[4] = 1'b0; d_exp[4] = 0;
        d_ang[5] = 32'h0000_0000; d_sel[5] = 1'b0; d_exp[5] = ONE;
        d_ang[6] = 32'h2000_0000; d_sel[6] = 1'b1; d_exp[6] = 64'sh2D41_3CCD;

        reset          = 1'b1;
        sin_calc_start = 1'b0;
        in_angle       = '0;
        in_sine_cosine = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_busy",  longint'(busy), 0);
        check_eq("reset_valid", longint'(out_valid), 0);
        check_eq("reset_value", longint'(out_value), 0);
        @(negedge clock) reset = 1'b0;

        // Abort a computation with reset partway through ROTATE
        @(negedge clock);
        in_angle       = 32'h1000_0000;
        in_sine_cosine = 1'b1;
        sin_calc_start = 1'b1;
        @(posedge clock);
        #1 sin_calc_start = 1'b0;
        check_eq("busy_after_start", longint'(busy), 1);
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check_eq("midreset_busy",  longint'(busy), 0);
        check_eq("midreset_value", longint'(out_value), 0);
        check_eq("midreset_valid", longint'(out_valid), 0);
        @(negedge clock) reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) pulses++;
        end
        check_eq("midreset_no_valid", longint'(pulses), 0);

        @(negedge clock);
        run_op(32'h1000_0000, 1'b1, v, lat);
        check_near("after_reset_value", v, model(32'h1000_0000, 1'b1));
        check_eq("after_reset_latency", longint'(lat), longint'(LAT));

        // Directed angles, including quadrant boundaries and +/-1.0
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            run_op(d_ang[i], d_sel[i], v, lat);
            check_near($sformatf("directed%0d_value", i), v, d_exp[i]);
            check_eq($sformatf("directed%0d_latency", i), longint'(lat), longint'(LAT));
        end

        // Back-to-back: start on the out_valid cycle of the previous result
        check_eq("b2b_valid_high", longint'(out_valid), 1);
        run_op(32'h6000_0000, 1'b0, v, lat);
        check_near("b2b_value", v, -64'sh2D41_3CCD);
        check_eq("b2b_latency", longint'(lat), longint'(LAT));

        // Second start while busy must be ignored
        @(negedge clock);
        in_angle       = 32'h1555_0000;
        in_sine_cosine = 1'b1;
        sin_calc_start = 1'b1;
        @(posedge clock);
        #1 sin_calc_start = 1'b0;
        pulses = 0;
        lat    = 0;
        v      = 0;
        for (e = 1; e <= 70; e++) begin
            @(posedge clock);
            #1;
            if (e == 10) begin
                in_angle       = 32'h7000_0000;
                in_sine_cosine = 1'b0;
                sin_calc_start = 1'b1;
            end
            if (e == 11) sin_calc_start = 1'b0;
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    v   = longint'($signed(out_value));
                    lat = e;
                end
            end
        end
        check_eq("busy_start_pulses", longint'(pulses), 1);
        check_eq("busy_start_latency", longint'(lat), longint'(LAT));
        check_near("busy_start_value", v, model(32'h1555_0000, 1'b1));

        // Random angles and selects against the real-math model
        repeat (16) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            @(negedge clock);
            run_op(ra, rs, v, lat);
            check_near($sformatf("rand_%h_%0d_value", ra, rs), v, model(ra, rs));
            check_eq($sformatf("rand_%h_%0d_latency", ra, rs), longint'(lat), longint'(LAT));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sin_cos_cordic.md
Name: sin_cos_cordic

Overview:
- Iterative rotation-mode CORDIC that computes the sine or cosine of a normalized angle.
- Sits directly downstream of the code decoder. It takes the decoder's angle, sine/cosine select and start pulse, and returns a signed fixed-point value the decoder latches as its output.
- Adds quadrant folding and output fixup; one result per ITERATIONS+1 cycles; out_valid is provided so consumers need not rely on a fixed delay.

Parameters:
- DATA_WIDTH, 32, width of angle input and result output.
- ITERATIONS, 30, CORDIC micro-rotations; legal range 8..30 (atan table length).
- ITER_CNT_WIDTH, 5, width of iteration counter; must hold ITERATIONS-1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- sin_calc_start  in  1  one-cycle request; sampled only in IDLE.
- in_angle  in  DATA_WIDTH  unsigned angle in turns, Q0.DATA_WIDTH (0x4000_0000 = quarter turn).
- in_sine_cosine  in  1  1 = sine, 0 = cosine; sampled with start.
- busy  out  1  high while a computation is in flight.
- out_valid  out  1  one-cycle pulse, out_value updated.
- out_value  out  DATA_WIDTH  signed Q2.(DATA_WIDTH-2) result; held until next result.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0; out_valid=0; out_value=0; x/y/z/counter/quadrant/select cleared. Reset mid-computation abandons it, with no out_valid.
- States: IDLE, ROTATE, FIXUP.
- IDLE: if sin_calc_start=1 at edge k:
  - latch quad=in_angle[MSB:MSB-1] and select;
  - x=CORDIC_GAIN_INV, y=0, z=in_angle with top two bits cleared (zero-extended to DATA_WIDTH+1 signed);
  - counter=0, busy=1, go ROTATE.
- IDLE with start=0: hold.
- ROTATE: one micro-rotation per cycle, iteration i=counter:
  - d = +1 if z>=0 else -1;
  - x' = x - d*(y>>>i);
  - y' = y + d*(x>>>i);
  - z' = z - d*ATAN_TURNS[i].
  - x, y are DATA_WIDTH+2 bits signed, arithmetic shift, truncating.
  - Counter increments. After iteration ITERATIONS-1 go FIXUP.
- FIXUP (one cycle): select by quad, take sine or cosine per select, truncate to DATA_WIDTH, register into out_value; out_valid=1 next cycle, busy=0, go IDLE.
  - q0: sin=y, cos=x.
  - q1: sin=x, cos=-y.
  - q2: sin=-y, cos=-x.
  - q3: sin=-x, cos=y.
- Latency: start at edge k gives out_valid high for cycle following edge k+ITERATIONS+1; busy high cycles k+1..k+ITERATIONS+1.
- Back-to-back: start asserted while out_valid=1 (state IDLE) is accepted.
- start while busy: ignored, no queueing, no error flag.
- Boundaries:
  - Angle 0 and exact quadrant boundaries take the q-fold path with residual 0.
  - Result of magnitude 1.0 is representable (Q2 headroom); the ±1.0 extremes must not wrap.
- Accuracy: |error| <= 32 LSB of Q2.30 at ITERATIONS=30.

Optional Feature:
- Macro: SIN_COS_CORDIC_ROUND_EN.
- Defined: FIXUP rounds to nearest by adding half-LSB before the final narrowing from DATA_WIDTH+2. Saturation at ±1.0 is guaranteed; latency unchanged.
- Undefined: plain truncation as above.

Decomposition:
- Package sin_cos_cordic_pkg:
  - ATAN_TURNS[0:29]: round(atan(2^-i)/(2*pi)*2^DATA_WIDTH).
  - CORDIC_GAIN_INV: round(0.6072529350*2^30).
  - State enum typedef (IDLE/ROTATE/FIXUP).
  - Quadrant typedef.
- Sub-module cordic_micro_rotation: combinational single-iteration datapath (x, y, z, i in; x', y', z' out), instantiated once and reused every cycle.

Test Plan:
- Reset mid-ROTATE: start angle 0x1000_0000, assert reset at cycle 5 → busy=0, out_value=0, no out_valid; next start completes normally.
- Sine, angle 0x0000_0000 → out_value within ±32 of 0x0000_0000, out_valid exactly ITERATIONS+1 cycles after start.
- Sine, angle 0x4000_0000 → out_value within ±32 of 0x4000_0000 (+1.0).
- Cosine, angle 0x8000_0000 → out_value within ±32 of 0xC000_0000 (-1.0); no wrap to positive.
- Sine, angle 0x2000_0000 → within ±32 of 0x2D41_3CCD (0.7071). Then a second start on the out_valid cycle is accepted.
- Start pulsed again while busy → ignored; exactly one out_valid; result matches first request.
